// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: N add/shift iterations, registered 2N-bit product.
// Define MULT_SIGNED_EN to compile in radix-2 Booth signed mode (signed_mode input).
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic                     clock,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic                     signed_mode,
  input  logic [N-1:0]             multiplicand,
  input  logic [N-1:0]             multiplier,
  output logic                     busy,
  output logic                     done,
  output logic [2*N-1:0]           product,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [N-1:0]     r_m;
  logic [N:0]       r_a;
  logic [N-1:0]     r_q;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [2*N-1:0]   r_product;

  logic [N:0]       w_a_add;
  logic [N:0]       w_a_sh;
  logic [N-1:0]     w_q_sh;
  logic             w_sh_in;

`ifdef MULT_SIGNED_EN
  logic r_mode;
  logic r_qm1;

  // A[N] is the carry in unsigned mode and the sign guard in Booth mode.
  always_comb begin
    w_a_add = r_a;
    if (!r_mode) begin
      if (r_q[0]) w_a_add = {1'b0, r_a[N-1:0]} + {1'b0, r_m};
    end else begin
      case ({r_q[0], r_qm1})
        2'b10:   w_a_add = r_a - {r_m[N-1], r_m};
        2'b01:   w_a_add = r_a + {r_m[N-1], r_m};
        default: w_a_add = r_a;
      endcase
    end
  end

  assign w_sh_in = r_mode & r_a[N];
`else
  logic w_unused;
  assign w_unused = signed_mode;

  always_comb begin
    w_a_add = r_a;
    if (r_q[0]) w_a_add = {1'b0, r_a[N-1:0]} + {1'b0, r_m};
  end

  assign w_sh_in = 1'b0;
`endif

  assign w_a_sh = {w_sh_in, r_a[N:1]};
  assign w_q_sh = {r_a[0], r_q[N-1:1]};

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef MULT_SIGNED_EN
      r_mode    <= 1'b0;
      r_qm1     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_count <= CW'(N);
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_ADD;
`ifdef MULT_SIGNED_EN
            r_mode  <= signed_mode;
            r_qm1   <= 1'b0;
`endif
          end
        end
        S_ADD: begin
          r_a     <= w_a_add;
          r_count <= r_count - CW'(1);
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_a <= w_a_sh;
          r_q <= w_q_sh;
`ifdef MULT_SIGNED_EN
          r_qm1 <= r_q[0];
`endif
          // Product is taken from the shifted value so it lands with done.
          if (r_count == '0) begin
            r_product <= {w_a_sh[N-1:0], w_q_sh};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign count   = r_count;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (N=8).
module tb_seq_multiplier;

  localparam int N = 8;

  logic           clock;
  logic           n_reset;
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic [3:0]     count;

  int total = 0;
  int bad   = 0;

  seq_multiplier #(.N(N)) dut (
    .clock        (clock),
    .n_reset      (n_reset),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .count        (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Launch one multiply, count busy cycles and check the product.
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sm, input logic [15:0] exp);
    int nb;
    multiplicand = a;
    multiplier   = b;
    signed_mode  = sm;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(posedge clock); #1;
    end
    chk({tag, "_cycles"}, nb, 32'd16);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_prod"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int nb;
    n_reset = 1'b0;
    start = 1'b0;
    signed_mode = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    @(posedge clock); #1;

    // 13 x 11 with count trace.
    multiplicand = 8'd13;
    multiplier = 8'd11;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("c_add0_count", 32'(count), 32'd8);
    @(posedge clock); #1;
    chk("c_sh0_count", 32'(count), 32'd7);
    chk("c_sh0_busy", 32'(busy), 32'd1);
    nb = 2;
    while (busy && nb < 40) begin
      @(posedge clock); #1;
      if (busy) nb++;
    end
    chk("c_cycles", nb, 32'd16);
    chk("c_done", 32'(done), 32'd1);
    chk("c_prod", 32'(product), 32'h008F);
    chk("c_count_end", 32'(count), 32'd0);
    @(posedge clock); #1;
    chk("c_done_hold", 32'(done), 32'd1);
    chk("c_prod_hold", 32'(product), 32'h008F);

    run_mul("u255", 8'd255, 8'd255, 1'b0, 16'hFE01);
    run_mul("u_neg7", 8'hF9, 8'h05, 1'b0, 16'h04DD);
`ifdef MULT_SIGNED_EN
    run_mul("s_neg7", 8'hF9, 8'h05, 1'b1, 16'hFFDD);
`else
    run_mul("s_neg7", 8'hF9, 8'h05, 1'b1, 16'h04DD);
`endif
    run_mul("s_min", 8'h80, 8'h80, 1'b1, 16'h4000);
`ifdef MULT_SIGNED_EN
    run_mul("s_mix", 8'h05, 8'hFD, 1'b1, 16'hFFF1);
`else
    run_mul("s_mix", 8'h05, 8'hFD, 1'b1, 16'h04F1);
`endif

    // start held high: 3x4, operands disturbed mid-run, then 6x7 back-to-back.
    multiplicand = 8'd3;
    multiplier = 8'd4;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    multiplicand = 8'd9;
    multiplier = 8'd9;
    nb = 1;
    while (!done && nb < 40) begin
      @(posedge clock); #1;
      nb++;
      if (nb == 8) begin
        multiplicand = 8'd6;
        multiplier = 8'd7;
      end
    end
    chk("b2b_cycles", nb, 32'd17);
    chk("b2b_prod1", 32'(product), 32'd12);
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b_done_drop", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(posedge clock); #1;
    end
    chk("b2b_cycles2", nb, 32'd16);
    chk("b2b_prod2", 32'(product), 32'd42);

    // Asynchronous reset mid-operation.
    multiplicand = 8'd200;
    multiplier = 8'd100;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    n_reset = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_prod", 32'(product), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    @(posedge clock); #1;
    chk("ar_idle", 32'(busy), 32'd0);
    run_mul("ar_2x3", 8'd2, 8'd3, 1'b0, 16'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
